aes_core_arbiter: RTL and testbench
===================================

// Module: aes_core_arbiter
// PURPOSE
//  Shares one aes_encrypt core between NUM_REQ requesters. Round-robin grant, one
//  request in flight; latches the request, pulses core start, waits for done, returns
//  the ciphertext tagged with the requester id. A watchdog aborts hung operations.
//  Sits between the host-side request ports and the single aes_encrypt instance.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..8)
//  ID_W           2   width of requester id, = $clog2(NUM_REQ)
//  TIMEOUT_CYCLES 64  max cycles in WAIT before abort (>=2, <=2^16)
// PORTS
//  clk             in   1            system clock, rising edge
//  rst_n           in   1            synchronous active-low reset
//  req_valid       in   NUM_REQ      per-requester request valid
//  req_ready       out  NUM_REQ      per-requester accept (one-hot or zero)
//  req_plaintext   in   NUM_REQ*128  requester i at bits [i*128 +: 128]
//  req_key         in   NUM_REQ*128  requester i at bits [i*128 +: 128]
//  rsp_valid       out  1            response valid
//  rsp_ready       in   1            response consumer ready
//  rsp_id          out  ID_W         requester id of the response
//  rsp_ciphertext  out  128          result; 0 on error
//  rsp_error       out  1            1 = watchdog abort
//  aes_start       out  1            core start, one-cycle pulse
//  aes_plaintext   out  128          core plaintext, held stable START..DRAIN
//  aes_key         out  128          core key, held stable START..DRAIN
//  aes_ciphertext  in   128          core result
//  aes_done        in   1            core done (level; may stay high)
//  busy            out  1            1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, all outputs 0, holding regs 0,
//   last_grant=NUM_REQ-1 (req 0 wins first), timer=0. Mid-operation reset aborts
//   with no response; core shares rst_n.
//  IDLE: g = first i with req_valid[i], scanning last_grant+1 upward, wrapping.
//   req_ready[g]=1 combinationally (only in IDLE, only if some valid). On transfer:
//   latch plaintext/key/id=g, last_grant<=g, -> START. No valid: stay IDLE.
//  START: aes_start=1 exactly this cycle; timer<=0; -> WAIT.
//  WAIT: aes_done=1 -> rsp_ciphertext<=aes_ciphertext, rsp_error<=0, -> RESP.
//   else timer==TIMEOUT_CYCLES-1 -> rsp_ciphertext<=0, rsp_error<=1, -> RESP.
//   else timer<=timer+1. done wins if coincident with timeout.
//  RESP: rsp_valid=1, rsp_id/ciphertext/error stable until rsp_ready=1; on
//   handshake -> DRAIN. Backpressure unbounded; no new request accepted.
//  DRAIN: wait until aes_done==0 (stale done never satisfies the next WAIT);
//   -> IDLE. If done already 0, one cycle here.
//  Latency: accept at cycle T, aes_start at T+1, done seen at T+k -> rsp_valid at
//   T+k+1. Min accept-to-accept: 5 cycles (accept, START, WAIT, RESP, DRAIN).
//  req_valid changes/drop in non-IDLE states are ignored; req_ready=0 there.
//  Fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.
// TESTING
//  1. Req0 pt=00112233445566778899aabbccddeeff key=000102..0f -> one aes_start pulse,
//     rsp_id=0, rsp_ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_error=0.
//  2. All 4 req_valid held high from reset, 8 ops -> grant order 0,1,2,3,0,1,2,3.
//  3. Stub core never raises done, TIMEOUT_CYCLES=64 -> rsp_valid exactly 65 cycles
//     after aes_start, rsp_error=1, rsp_ciphertext=0; next request still served.
//  4. rsp_ready low 20 cycles -> rsp fields stable, req_ready all 0, aes_start silent.
//  5. Core holds done high after response -> FSM stays in DRAIN until done falls,
//     next op's WAIT does not complete early.
//  6. rst_n=0 during WAIT -> next edge: busy=0, rsp_valid=0, last_grant=NUM_REQ-1.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter that shares one aes_encrypt core between NUM_REQ requesters,
// with one operation in flight, tagged responses and a watchdog abort for hung operations.
//
// state | meaning
// IDLE  | scan requesters round-robin, accept the first valid one
// START | pulse aes_start, arm watchdog
// WAIT  | wait for aes_done or watchdog expiry
// RESP  | present response until rsp_ready
// DRAIN | wait for aes_done to fall so a stale done cannot end the next WAIT
module aes_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_plaintext,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [127:0]           rsp_ciphertext,
    output logic                   rsp_error,
    output logic                   aes_start,
    output logic [127:0]           aes_plaintext,
    output logic [127:0]           aes_key,
    input  logic [127:0]           aes_ciphertext,
    input  logic                   aes_done,
    output logic                   busy
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_DRAIN} state_t;

    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;
    logic            hi_found;
    logic            lo_found;
    logic            grant_found;
    logic [15:0]     timer;

    // Prefer the lowest valid index above last_grant; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_id    = '0;
        lo_id    = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_id    = ID_W'(i);
                lo_found = 1'b1;
                if (i > int'(last_grant)) begin
                    hi_id    = ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        grant_id    = hi_found ? hi_id : lo_id;
        grant_found = lo_found;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (aes_done || timer == 16'd0) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_DRAIN;
            S_DRAIN: if (!aes_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
        aes_start = (state == S_START);
        rsp_valid = (state == S_RESP);
        busy      = (state != S_IDLE);
    end

    assign rsp_id = cur_id;

    // Watchdog is a down-counter: loaded at START, abort when it reaches zero in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aes_plaintext  <= '0;
            aes_key        <= '0;
            cur_id         <= '0;
            last_grant     <= ID_W'(NUM_REQ - 1);
            timer          <= '0;
            rsp_ciphertext <= '0;
            rsp_error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        aes_plaintext <= req_plaintext[grant_id*128 +: 128];
                        aes_key       <= req_key[grant_id*128 +: 128];
                        cur_id        <= grant_id;
                        last_grant    <= grant_id;
                    end
                end
                S_START: timer <= TIMER_LOAD;
                S_WAIT: begin
                    if (aes_done) begin
                        rsp_ciphertext <= aes_ciphertext;
                        rsp_error      <= 1'b0;
                    end else if (timer == 16'd0) begin
                        rsp_ciphertext <= '0;
                        rsp_error      <= 1'b1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter; the bench itself plays the aes_encrypt core.
module tb_aes_core_arbiter;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req_valid;
    logic [3:0]     req_ready;
    logic [511:0]   req_plaintext;
    logic [511:0]   req_key;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [127:0]   rsp_ciphertext;
    logic           rsp_error;
    logic           aes_start;
    logic [127:0]   aes_plaintext;
    logic [127:0]   aes_key;
    logic [127:0]   aes_ciphertext;
    logic           aes_done;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc;

    aes_core_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_plaintext  (req_plaintext),
        .req_key        (req_key),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_ciphertext (rsp_ciphertext),
        .rsp_error      (rsp_error),
        .aes_start      (aes_start),
        .aes_plaintext  (aes_plaintext),
        .aes_key        (aes_key),
        .aes_ciphertext (aes_ciphertext),
        .aes_done       (aes_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int bound);
        int n = 0;
        while (aes_start !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk("start_seen", 128'(aes_start), 128'h1);
    endtask

    task automatic wait_rsp(input int bound, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk("rsp_seen", 128'(rsp_valid), 128'h1);
    endtask

    function automatic logic [127:0] pt_of(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    function automatic logic [127:0] key_of(input int i);
        return {4{32'hBEEF0000 + 32'(i)}};
    endfunction

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_plaintext  = '0;
        req_key        = '0;
        rsp_ready      = 1'b1;
        aes_done       = 1'b0;
        aes_ciphertext = '0;
        tick();
        tick();
        chk("rst_busy",      128'(busy),           128'h0);
        chk("rst_rsp_valid", 128'(rsp_valid),      128'h0);
        chk("rst_req_ready", 128'(req_ready),      128'h0);
        chk("rst_aes_start", 128'(aes_start),      128'h0);
        chk("rst_aes_pt",    aes_plaintext,        128'h0);
        chk("rst_rsp_ct",    rsp_ciphertext,       128'h0);
        rst_n = 1'b1;

        // FIPS-197 vector through requester 0
        req_plaintext[0 +: 128] = 128'h00112233445566778899aabbccddeeff;
        req_key[0 +: 128]       = 128'h000102030405060708090a0b0c0d0e0f;
        req_valid = 4'b0001;
        #1;
        chk("t1_req_ready", 128'(req_ready), 128'h1);
        tick();
        chk("t1_start",     128'(aes_start), 128'h1);
        chk("t1_aes_pt",    aes_plaintext, 128'h00112233445566778899aabbccddeeff);
        chk("t1_aes_key",   aes_key,       128'h000102030405060708090a0b0c0d0e0f);
        chk("t1_ready_off", 128'(req_ready), 128'h0);
        req_valid = 4'b0000;
        tick();
        chk("t1_start_pulse", 128'(aes_start), 128'h0);
        tick();
        aes_done       = 1'b1;
        aes_ciphertext = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tick();
        chk("t1_rsp_valid", 128'(rsp_valid), 128'h1);
        chk("t1_rsp_id",    128'(rsp_id),    128'h0);
        chk("t1_rsp_ct",    rsp_ciphertext,  128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("t1_rsp_err",   128'(rsp_error), 128'h0);
        aes_done = 1'b0;
        tick();
        chk("t1_drain_busy", 128'(busy), 128'h1);
        tick();
        chk("t1_idle_busy",  128'(busy), 128'h0);

        // Round robin with all requesters valid from reset
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_plaintext[i*128 +: 128] = pt_of(i);
            req_key[i*128 +: 128]       = key_of(i);
        end
        req_valid = 4'b1111;
        tick();
        rst_n = 1'b1;
        chk("t2_first_ready", 128'(req_ready), 128'h1);
        for (int k = 0; k < 8; k++) begin
            wait_start(20);
            chk("t2_aes_pt",  aes_plaintext, pt_of(k % 4));
            chk("t2_aes_key", aes_key,       key_of(k % 4));
            tick();
            aes_done       = 1'b1;
            aes_ciphertext = 128'h1000 + 128'(k);
            wait_rsp(20, n_cyc);
            chk("t2_rsp_id", 128'(rsp_id), 128'(k % 4));
            chk("t2_rsp_ct", rsp_ciphertext, 128'h1000 + 128'(k));
            aes_done = 1'b0;
        end
        req_valid = 4'b0000;
        tick();
        tick();

        // Watchdog: core never answers
        req_valid = 4'b0010;
        wait_start(20);
        req_valid = 4'b0000;
        wait_rsp(200, n_cyc);
        chk("t3_latency", 128'(n_cyc),     128'd65);
        chk("t3_rsp_err", 128'(rsp_error), 128'h1);
        chk("t3_rsp_ct",  rsp_ciphertext,  128'h0);
        chk("t3_rsp_id",  128'(rsp_id),    128'h1);
        tick();
        tick();
        req_valid = 4'b0100;
        wait_start(20);
        req_valid = 4'b0000;
        tick();
        aes_done       = 1'b1;
        aes_ciphertext = 128'hA5A5;
        wait_rsp(20, n_cyc);
        chk("t3_next_id",  128'(rsp_id),    128'h2);
        chk("t3_next_err", 128'(rsp_error), 128'h0);
        chk("t3_next_ct",  rsp_ciphertext,  128'hA5A5);
        aes_done = 1'b0;
        tick();
        tick();

        // Response backpressure
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        wait_start(20);
        chk("t4_aes_pt", aes_plaintext, pt_of(3));
        tick();
        aes_done       = 1'b1;
        aes_ciphertext = 128'hBEEFCAFE;
        wait_rsp(20, n_cyc);
        aes_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk("t4_rsp_valid", 128'(rsp_valid), 128'h1);
            chk("t4_rsp_id",    128'(rsp_id),    128'h3);
            chk("t4_rsp_ct",    rsp_ciphertext,  128'hBEEFCAFE);
            chk("t4_rsp_err",   128'(rsp_error), 128'h0);
            chk("t4_req_ready", 128'(req_ready), 128'h0);
            chk("t4_aes_start", 128'(aes_start), 128'h0);
            tick();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        chk("t4_rsp_done", 128'(rsp_valid), 128'h0);
        tick();
        chk("t4_idle", 128'(busy), 128'h0);

        // Core holds done high after the response
        req_valid = 4'b0001;
        wait_start(20);
        req_valid = 4'b0000;
        tick();
        aes_done       = 1'b1;
        aes_ciphertext = 128'h5555;
        wait_rsp(20, n_cyc);
        chk("t5_rsp_ct", rsp_ciphertext, 128'h5555);
        tick();
        req_valid = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            chk("t5_drain_busy",  128'(busy),      128'h1);
            chk("t5_drain_ready", 128'(req_ready), 128'h0);
            chk("t5_drain_rsp",   128'(rsp_valid), 128'h0);
            tick();
        end
        aes_done = 1'b0;
        tick();
        chk("t5_idle_ready", 128'(req_ready), 128'h1);
        wait_start(20);
        req_valid = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t5_no_early", 128'(rsp_valid), 128'h0);
        end
        aes_done       = 1'b1;
        aes_ciphertext = 128'h7777;
        wait_rsp(20, n_cyc);
        chk("t5_rsp_ct2", rsp_ciphertext, 128'h7777);
        aes_done = 1'b0;
        tick();
        tick();

        // Reset during WAIT
        req_valid = 4'b0010;
        wait_start(20);
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_busy",      128'(busy),      128'h0);
        chk("t6_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("t6_aes_start", 128'(aes_start), 128'h0);
        req_valid = 4'b1111;
        rst_n = 1'b1;
        #1;
        chk("t6_grant0", 128'(req_ready), 128'h1);
        tick();
        chk("t6_start",  128'(aes_start), 128'h1);
        chk("t6_aes_pt", aes_plaintext,   pt_of(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
